// File: rtl/fn_sweep_ctrl_pkg.sv
// rtl/fn_sweep_ctrl_pkg.sv - shared types and constants for the function-block sweep sequencer
package fn_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int          NUM_VECTORS = 16;
  // F(A,B,C,D) = PI M(0,1,2,8,10,12,14); bit i holds F at {A,B,C,D} = i
  localparam logic [15:0] FN_EXPECTED = 16'hAAF8;

endpackage

// File: rtl/fn_sweep_ctrl_settle_timer.sv
// rtl/fn_sweep_ctrl_settle_timer.sv - per-vector settle counter, expires on its last settle cycle
module fn_sweep_ctrl_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam logic [3:0] LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = 4'd0;
    end else if (enable) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With no settle window the FSM never enters SETTLE, so the timer never expires
  assign expired = (SETTLE_CYCLES != 0) && (cnt_q == LAST);

endmodule

// File: rtl/fn_sweep_ctrl.sv
// rtl/fn_sweep_ctrl.sv - drives ABCD through all 16 vectors, captures F and checks it
// against the expected truth table, reporting pass, mismatch map and first failing index.
module fn_sweep_ctrl
  import fn_sweep_ctrl_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = FN_EXPECTED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  abcd,
  input  logic        f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [15:0] mismatch_map,
  output logic        pass,
  output logic [3:0]  first_fail
);

  localparam state_e FIRST_ST = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;

  state_e      state_q;
  logic [3:0]  vec_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] tt_q;
  logic [15:0] mm_q;
  logic        pass_q;
  logic [3:0]  ff_q;

  logic [15:0] tt_d;
  logic [15:0] mm_d;
  logic [3:0]  ff_d;
  logic        tmr_load;
  logic        tmr_en;
  logic        tmr_expired;

  assign tmr_load = (state_q == ST_IDLE) || (state_q == ST_SAMPLE);
  assign tmr_en   = (state_q == ST_SETTLE);

  fn_sweep_ctrl_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  // Results are computed from the table including the sample taken this cycle,
  // so they are already valid in the DONE cycle.
  always_comb begin
    tt_d        = tt_q;
    tt_d[vec_q] = f_in;
    mm_d        = tt_d ^ EXPECTED;
    ff_d        = 4'd0;
    for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
      if (mm_d[i]) begin
        ff_d = 4'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= 16'd0;
      mm_q    <= 16'd0;
      pass_q  <= 1'b0;
      ff_q    <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_q <= FIRST_ST;
            vec_q   <= 4'd0;
            busy_q  <= 1'b1;
            tt_q    <= 16'd0;
            mm_q    <= 16'd0;
            pass_q  <= 1'b0;
            ff_q    <= 4'd0;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state_q <= ST_IDLE;
            vec_q   <= 4'd0;
            busy_q  <= 1'b0;
          end else if (tmr_expired) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            state_q <= ST_IDLE;
            vec_q   <= 4'd0;
            busy_q  <= 1'b0;
          end else begin
            tt_q <= tt_d;
            if (vec_q == 4'(NUM_VECTORS - 1)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              mm_q    <= mm_d;
              pass_q  <= (mm_d == 16'd0);
              ff_q    <= ff_d;
            end else begin
              state_q <= FIRST_ST;
              vec_q   <= vec_q + 4'd1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          vec_q   <= 4'd0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign abcd         = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign truth_table  = tt_q;
  assign mismatch_map = mm_q;
  assign pass         = pass_q;
  assign first_fail   = ff_q;

endmodule

// File: tb/tb_fn_sweep_ctrl.sv
// tb/tb_fn_sweep_ctrl.sv - scoreboard bench for fn_sweep_ctrl with a table-driven F model
module tb_fn_sweep_ctrl;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        f_in;
  logic [3:0]  abcd;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
  logic [15:0] mismatch_map;
  logic        pass;
  logic [3:0]  first_fail;

  logic        start0;
  logic        f_in0;
  logic [3:0]  abcd0;
  logic        busy0;
  logic        done0;
  logic [15:0] tt0;
  logic [15:0] mm0;
  logic        pass0;
  logic [3:0]  ff0;

  logic [15:0] tab;
  logic [15:0] ref_tab;
  logic        noise;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int act     = 0;
  int act_start = 0;

  typedef struct {
    logic [15:0] tt;
    logic [15:0] mm;
    logic        pass;
    logic [3:0]  ff;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    noise <= 1'($urandom);
  end

  // The function block under test: a lookup of the currently applied vector
  always_comb f_in = busy ? tab[abcd] : noise;
  assign f_in0 = ref_tab[abcd0];

  fn_sweep_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .abcd         (abcd),
    .f_in         (f_in),
    .busy         (busy),
    .done         (done),
    .truth_table  (truth_table),
    .mismatch_map (mismatch_map),
    .pass         (pass),
    .first_fail   (first_fail)
  );

  fn_sweep_ctrl #(.SETTLE_CYCLES(0)) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start0),
    .abort        (1'b0),
    .abcd         (abcd0),
    .f_in         (f_in0),
    .busy         (busy0),
    .done         (done0),
    .truth_table  (tt0),
    .mismatch_map (mm0),
    .pass         (pass0),
    .first_fail   (ff0)
  );

  function automatic logic [15:0] build_ref();
    logic [15:0] t;
    for (int i = 0; i < 16; i++) begin
      t[i] = !(i == 0 || i == 1 || i == 2 || i == 8 || i == 10 || i == 12 || i == 14);
    end
    return t;
  endfunction

  function automatic logic [3:0] lowest_set(logic [15:0] m);
    int i = 0;
    while (i < 16 && !m[i]) i++;
    return (i == 16) ? 4'd0 : 4'(i);
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic monitor();
    int   k;
    int   seq_err = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n || act == 0) begin
        seq_err = 0;
      end else begin
        k = cyc - act_start;
        if (k >= 0 && k < 16 * (S + 1)) begin
          if (abcd !== 4'(k / (S + 1)) || busy !== 1'b1) seq_err++;
        end
      end
      if (rst_n && done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
          check("truth_table", 32'(truth_table), 32'(e.tt));
          check("mismatch_map", 32'(mismatch_map), 32'(e.mm));
          check("pass", 32'(pass), 32'(e.pass));
          check("first_fail", 32'(first_fail), 32'(e.ff));
          check("abcd_at_done", 32'(abcd), 32'd15);
          check("busy_at_done", 32'(busy), 32'd1);
          check("abcd_sequence_errors", 32'(seq_err), 32'd0);
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start     = 1'b1;
    act_start = cyc + 1;
    act       = 1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic run_sweep(logic [15:0] t);
    exp_t e;
    int   n = 0;
    tab = t;
    e.tt   = t;
    e.mm   = t ^ ref_tab;
    e.pass = (e.mm == 16'd0);
    e.ff   = lowest_set(e.mm);
    @(negedge clk);
    e.done_cyc = cyc + 1 + 16 * (S + 1);
    exp_q.push_back(e);
    start     = 1'b1;
    act_start = cyc + 1;
    act       = 1;
    @(negedge clk);
    start = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
    act = 0;
    check("done_is_pulse", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("pass_held", 32'(pass), 32'(e.pass));
    check("mismatch_held", 32'(mismatch_map), 32'(e.mm));
    check("abcd_idle", 32'(abcd), 32'd0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_abcd"}, 32'(abcd), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_truth_table"}, 32'(truth_table), 32'd0);
    check({tag, "_mismatch_map"}, 32'(mismatch_map), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_first_fail"}, 32'(first_fail), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ref_tab = build_ref();
    tab     = ref_tab;
    rst_n   = 1'b0;
    start   = 1'b1;
    abort   = 1'b0;
    start0  = 1'b0;
    fork
      monitor();
    join_none

    // Reset overrides start
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_dut0_busy", 32'(busy0), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("idle_after_reset");

    run_sweep(ref_tab);
    run_sweep(16'h0000);
    run_sweep(~ref_tab);
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_sweep(16'($urandom));
    end

    // Abort during the first SETTLE cycle of vector 5
    tab = ref_tab;
    pulse_start();
    n = 0;
    while (cyc < act_start + 5 * (S + 1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_vec5", 32'(abcd), 32'd5);
    act   = 0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_abcd", 32'(abcd), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_partial_table", 32'(truth_table), 32'(ref_tab & 16'h001F));
    check("abort_pass", 32'(pass), 32'd0);

    // start with abort in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check("start_abort_idle_busy", 32'(busy), 32'd0);
    check("start_abort_table_kept", 32'(truth_table), 32'(ref_tab & 16'h001F));
    repeat (60) @(negedge clk);

    // Re-pulse start mid-sweep, then reset at vector 10
    pulse_start();
    while (cyc < act_start + 7 * (S + 1)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < act_start + 10 * (S + 1)) @(negedge clk);
    check("repulse_ignored_abcd", 32'(abcd), 32'd10);
    check("repulse_busy", 32'(busy), 32'd1);
    act   = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("midsweep_reset");
    run_sweep(ref_tab);

    // Zero-settle instance: one vector per cycle
    @(negedge clk);
    start0 = 1'b1;
    act_start = cyc + 1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (done0 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("s0_done_cycle", 32'(cyc - act_start), 32'd16);
    check("s0_truth_table", 32'(tt0), 32'(ref_tab));
    check("s0_mismatch_map", 32'(mm0), 32'd0);
    check("s0_pass", 32'(pass0), 32'd1);
    check("s0_first_fail", 32'(ff0), 32'd0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
